// File: rtl/sram_arbiter.sv
// Time-slot arbiter for the shared 512Kx8 SRAM: video, Z80 CPU and DMA each own whole slots.
// Define SRAM_ARB_STATS_EN to add the cpu-wait / dma-slot statistics counters.
//
//   state   | meaning
//   IDLE    | slot unowned, no strobes
//   VIDEO   | screen fetch owns the slot
//   CPU     | Z80 owns the slot, cpu_wait released
//   DMA     | DMA port owns the slot, ack at the last phase
module sram_arbiter #(
   parameter int SLOT_LEN     = 4,
   parameter int STARVE_LIMIT = 8
) (
   input  logic        clk28,
   input  logic        rst_n,
   input  logic        video_req,
   input  logic        cpu_req,
   input  logic        cpu_wr,
   input  logic        dma_req,
   input  logic        dma_wr,
   input  logic [18:0] dma_addr,
   input  logic [7:0]  dma_wdata,
   input  logic [7:0]  sram_rdata,
   output logic        video_grant,
   output logic        cpu_grant,
   output logic        dma_grant,
   output logic        sram_we,
   output logic        cpu_wait,
   output logic        dma_ack,
   output logic [7:0]  dma_rdata,
   output logic [2:0]  slot_phase
`ifdef SRAM_ARB_STATS_EN
   ,
   input  logic        stat_clear,
   output logic [15:0] stat_cpu_wait,
   output logic [15:0] stat_dma_slots
`endif
);

   localparam int SW = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
   localparam logic [2:0] PH_LAST = 3'(SLOT_LEN - 1);
   localparam logic [2:0] PH_CAP  = 3'(SLOT_LEN - 2);

   typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_CPU, S_DMA} state_t;

   state_t state, state_nxt;
   logic [2:0] phase;
   logic [SW-1:0] starve;
   logic boundary;

   // Address and write data are muxed onto the bus by the memory controller.
   logic unused_dma;
   assign unused_dma = ^{dma_addr, dma_wdata};

   assign boundary = (phase == PH_LAST);

   always_comb begin
      state_nxt = S_IDLE;
      if (video_req)                            state_nxt = S_VIDEO;
      else if (dma_req && starve == STARVE_MAX) state_nxt = S_DMA;
      else if (cpu_req)                         state_nxt = S_CPU;
      else if (dma_req)                         state_nxt = S_DMA;
   end

   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         phase       <= 3'd0;
         starve      <= '0;
         video_grant <= 1'b0;
         cpu_grant   <= 1'b0;
         dma_grant   <= 1'b0;
         dma_rdata   <= 8'hFF;
      end else begin
         phase <= boundary ? 3'd0 : 3'(phase + 3'd1);
         if (boundary) begin
            state       <= state_nxt;
            video_grant <= (state_nxt == S_VIDEO);
            cpu_grant   <= (state_nxt == S_CPU);
            dma_grant   <= (state_nxt == S_DMA);
            if (dma_req && state_nxt != S_DMA) begin
               if (starve != STARVE_MAX) starve <= SW'(starve + 1'b1);
            end else begin
               starve <= '0;
            end
         end
         if (state == S_DMA && phase == PH_CAP && !dma_wr) dma_rdata <= sram_rdata;
      end
   end

   // Strobe kept off the first and last phase for address setup and hold.
   assign sram_we    = (phase != 3'd0) && (phase != PH_LAST) &&
                       ((dma_grant && dma_wr) || (cpu_grant && cpu_wr));
   assign cpu_wait   = cpu_req && (state != S_CPU);
   assign dma_ack    = (state == S_DMA) && boundary && dma_req;
   assign slot_phase = phase;

`ifdef SRAM_ARB_STATS_EN
   always_ff @(posedge clk28 or negedge rst_n) begin
      if (!rst_n) begin
         stat_cpu_wait  <= 16'd0;
         stat_dma_slots <= 16'd0;
      end else if (stat_clear) begin
         stat_cpu_wait  <= 16'd0;
         stat_dma_slots <= 16'd0;
      end else begin
         if (cpu_wait && stat_cpu_wait != 16'hFFFF) stat_cpu_wait <= stat_cpu_wait + 16'd1;
         if (boundary && state_nxt == S_DMA && stat_dma_slots != 16'hFFFF)
            stat_dma_slots <= stat_dma_slots + 16'd1;
      end
   end
`endif

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Time-slot arbiter for the single external 512Kx8 SRAM shared by three requesters: screen fetch, Z80 CPU and a DMA port (boot rom2ram loader, future blitter). It runs on clk28 and divides time into fixed slots. Each slot it grants exactly one owner. It stretches the CPU via a wait output and performs the DMA handshake. The memory controller drives address and data muxing from the grant outputs.

Parameters:
SLOT_LEN, 4, clk28 cycles per slot; legal range 2..8.
STARVE_LIMIT, 8, consecutive slots a pending DMA request may lose to the CPU before it is promoted above the CPU.

Ports:
clk28  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
video_req  in  1  screen fetch wants the next slot
cpu_req  in  1  CPU memory cycle pending (mreq and not rfsh)
cpu_wr  in  1  CPU cycle is a write
dma_req  in  1  DMA request; held until dma_ack
dma_wr  in  1  DMA write (else read); stable while dma_req
dma_addr  in  19  DMA SRAM address; stable while dma_req
dma_wdata  in  8  DMA write data; stable while dma_req
sram_rdata  in  8  SRAM data bus as read back
video_grant  out  1  slot owned by video
cpu_grant  out  1  slot owned by CPU
dma_grant  out  1  slot owned by DMA
sram_we  out  1  write strobe request for the owned slot
cpu_wait  out  1  stall CPU clock; CPU request pending but not served
dma_ack  out  1  one-cycle pulse; DMA access completed
dma_rdata  out  8  captured DMA read data; valid from dma_ack
slot_phase  out  3  current phase within the slot, 0..SLOT_LEN-1

Behaviour:
- Reset values: all grants 0, sram_we 0, cpu_wait 0, dma_ack 0, dma_rdata 8'hFF, slot_phase 0, starve counter 0, state IDLE.
- Phase counter increments every clk28 and wraps SLOT_LEN-1 -> 0.
- Owner decision is made only on the cycle where the phase wraps to 0. The owner is held for the whole slot. Requests arriving mid-slot wait for the next boundary.
- State machine: states IDLE, VIDEO, CPU, DMA. At each boundary the next state is chosen by the first matching rule:
  - video_req -> VIDEO (always wins)
  - dma_req and starve==STARVE_LIMIT -> DMA
  - cpu_req -> CPU
  - dma_req -> DMA
  - otherwise -> IDLE
- Grants are registered and equal the state one-hot. In IDLE all grants are 0.
- Starve counter:
  - increments (saturating at STARVE_LIMIT) on each boundary where dma_req is high and DMA is not chosen;
  - clears when DMA is chosen or dma_req is low.
- sram_we:
  - DMA slot with dma_wr: high during phases 1..SLOT_LEN-2;
  - CPU slot with cpu_wr: same phases;
  - otherwise 0.
  - Never high in phase 0 or phase SLOT_LEN-1 (address setup/hold).
- DMA read: dma_rdata is captured from sram_rdata on the cycle where phase==SLOT_LEN-2 inside a DMA slot.
- dma_ack pulses high for exactly one cycle, at phase SLOT_LEN-1 of each DMA slot. The requester may drop or re-raise dma_req in the next cycle. Back-to-back DMA slots are allowed when video and CPU are idle.
- cpu_wait = cpu_req and not (state==CPU), combinational from registered state. It deasserts in the first cycle of a CPU slot.
- Simultaneous events:
  - video and DMA both at STARVE_LIMIT: video wins, starve counter stays saturated.
  - dma_req dropped mid-slot without ack: protocol violation; the slot still completes and no ack is issued if dma_req is low at SLOT_LEN-1.
- Asynchronous reset mid-slot: all outputs return to reset values immediately, and the in-flight access is abandoned with no ack.

Optional Feature:
SRAM_ARB_STATS_EN:
- When defined, adds input stat_clear (1 bit) and outputs stat_cpu_wait (16 bits) and stat_dma_slots (16 bits).
- stat_cpu_wait counts clk28 cycles with cpu_wait high. stat_dma_slots counts DMA slots granted.
- Both counters saturate at 16'hFFFF and clear synchronously on stat_clear and on reset.
- When not defined, these ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
1. Reset, no requests, run 20 cycles -> grants all 0, slot_phase cycles 0,1,2,3,0, cpu_wait 0, dma_rdata 8'hFF.
2. cpu_req raised at phase 2 -> cpu_wait high 2 cycles, cpu_grant from next phase 0 for 4 cycles; with cpu_wr=1, sram_we high at phases 1-2 only.
3. video_req and cpu_req both high continuously for 3 slots -> video_grant all 3 slots, cpu_wait high throughout, cpu_grant 0.
4. DMA read at addr 19'h12345, sram_rdata=8'hA5, other requesters idle -> dma_grant at next boundary, dma_ack one cycle at phase 3, dma_rdata=8'hA5.
5. cpu_req and dma_req continuously high -> CPU wins 8 slots, 9th slot DMA with dma_ack, starve counter returns to 0, then CPU again.
6. With SRAM_ARB_STATS_EN: 3 DMA slots then stat_clear -> stat_dma_slots reads 3 before the clear and 0 after it. Also reset asserted mid-DMA-slot -> no dma_ack, outputs at reset values.
